seg_disp_ctrl: RTL
==================

# seg_disp_ctrl

Display content scheduler in front of the 5-digit seven-segment scan driver. It selects which value is shown: measurement page, setting page, or an alarm override. Pages rotate on a timer or on a key press. The selected 16-bit binary value is converted to five BCD digits with a sequential double-dabble converter, and the digits are published with a one-cycle update strobe. The scan driver consumes `disp_bcd`/`disp_blank` directly, so the downstream path contains no combinational divide/modulo.

## Interface
- `CLK_FREQ`, default 50_000_000: sys_clk frequency in Hz.
- `PAGE_MS`, default 2000: auto-rotate page period in ms (≥1).
- `sys_clk` in 1: system clock; all logic runs on its rising edge.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `src0_val` in 16: measurement value (page 0).
- `src0_vld` in 1: one-cycle strobe, `src0_val` updated.
- `src1_val` in 16: setting value (page 1).
- `src1_vld` in 1: one-cycle strobe, `src1_val` updated.
- `alarm_req` in 1: level; while high, page 2 (alarm) is forced.
- `alarm_code` in 4: value shown on page 2 (0–15).
- `key_next` in 1: one-cycle pulse, already debounced; advance page.
- `auto_en` in 1: enables timed page rotation.
- `disp_bcd` out 20: [19:16] ten-thousands … [3:0] units.
- `disp_blank` out 5: per-digit blank; bit 4 = ten-thousands.
- `disp_page` out 2: page currently shown (0, 1, 2).
- `disp_upd` out 1: one-cycle pulse when `disp_bcd`/`disp_blank`/`disp_page` change.

## Operation
- **Reset values:**
  - `disp_bcd` = 0, `disp_page` = 0, `disp_upd` = 0.
  - `disp_blank` = 5'b11110 (5'b00000 without SEG_LZB_EN).
  - FSM in IDLE, `pend` = 1, so one conversion starts right after reset release.
- **Page select:**
  - `sel_page` is 0/1. It toggles on `key_next` or on page-timer expiry.
  - Effective page = 2 while `alarm_req` is high, else `sel_page`.
  - `key_next` is ignored while `alarm_req` is high. Timer expiry during an alarm toggles nothing and the timer restarts.
- **Page timer:**
  - A 1 ms prescaler counts 0..CLK_FREQ/1000−1; a ms counter counts 0..PAGE_MS−1.
  - The timer runs only when `auto_en` is high and `alarm_req` is low. Otherwise both counters are held at 0.
  - `key_next` clears both counters. The falling edge of `alarm_req` clears both counters.
  - `key_next` and expiry in the same cycle advance the page exactly once.
- **Trigger** (sets `pend`), any of:
  - `vld` of the source for the current effective page;
  - effective-page change;
  - `alarm_req` high with `alarm_code` changed.
  - Multiple triggers in one cycle, or during CONV, collapse into a single pending flag.
- **FSM:**
  - IDLE → CONV when `pend` = 1. On this edge: latch the effective page's value (alarm: zero-extended `alarm_code`), latch the page, clear `pend`, clear the iteration counter.
  - CONV: 16 iterations, one per cycle. Each iteration adds 3 to every BCD nibble ≥5, then shifts the binary MSB into the BCD LSB.
  - CONV → DONE after iteration 15.
  - DONE: register `disp_bcd`, `disp_blank`, `disp_page`; pulse `disp_upd`. Then go to IDLE, which restarts immediately if `pend` is set.
  - A trigger during CONV never aborts the conversion. The in-flight result is published, then the latest value is converted.
- **Arithmetic:**
  - 16-bit unsigned input, 20-bit BCD result. Max 65535 → 20'h65535.
  - No overflow case exists.

## Timing
- Trigger sampled at edge k → IDLE→CONV at edge k+1 (if IDLE) → `disp_upd` high during cycle after edge k+18. Worst-case 18 cycles; back-to-back conversions every 18 cycles.
- `disp_*` are registered and stable between `disp_upd` pulses.
- Page-timer expiry period = CLK_FREQ/1000 × PAGE_MS cycles exactly.
- Asynchronous reset mid-CONV discards the conversion. Outputs return to reset values; the forced conversion reruns after release.

## Configuration
- `SEG_LZB_EN` defined:
  - `disp_blank[i]` = 1 for each leading zero digit from the top. Digit 0 is never blanked.
  - Example: value 0 → 5'b11110; 42 → 5'b11100.
- Not defined: `disp_blank` is tied to 5'b00000 and no blanking logic is built.

## Structure
- Package `seg_disp_pkg`:
  - FSM state enum (IDLE, CONV, DONE);
  - page codes PG_MEAS=0, PG_SET=1, PG_ALARM=2;
  - constant NUM_DIG=5, BCD_W=20, BIN_W=16.
- Sub-module `bin2bcd_seq`:
  - iterative double dabble with `start`/`busy`/`done` and a 16-bit in, 20-bit out;
  - owns the CONV iteration counter.
- The top owns page select, timer, trigger/pending logic and the output registers.

## Test plan
- Reset release with `src0_val`=12345 → single `disp_upd` ≤19 cycles later; `disp_bcd`=20'h12345, `disp_blank`=5'b00000, page 0.
- `src0_val`=42 with `src0_vld` → `disp_bcd`=20'h00042, `disp_blank`=5'b11100; value 0 → 5'b11110; 65535 → 20'h65535.
- Three `src0_vld` pulses (values 1, 2, 3) within one CONV → exactly two `disp_upd`: first shows the value latched at start, second shows 3.
- CLK_FREQ=10_000, PAGE_MS=2, `auto_en`=1 → page toggles every 20 cycles. `key_next` 5 cycles after a toggle → immediate advance; next auto toggle 20 cycles after the key.
- `alarm_req`=1, `alarm_code`=7 → page 2, `disp_bcd`=20'h00007. `key_next` ignored. Release → previous page re-shown, timer restarted.
- Build without SEG_LZB_EN, value 42 → `disp_blank`=5'b00000.

Source files
------------

// File: rtl/seg_disp_pkg.sv
// rtl/seg_disp_pkg.sv - shared types and constants for the display content scheduler
package seg_disp_pkg;

    localparam int NUM_DIG = 5;
    localparam int BCD_W   = 20;
    localparam int BIN_W   = 16;

    localparam logic [1:0] PG_MEAS  = 2'd0;
    localparam logic [1:0] PG_SET   = 2'd1;
    localparam logic [1:0] PG_ALARM = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Marks every zero digit above the first non-zero one; the units digit always stays lit.
    function automatic logic [NUM_DIG-1:0] lead_zero_blank(input logic [BCD_W-1:0] bcd);
        logic [NUM_DIG-1:0] blank;
        logic               still_zero;
        blank      = '0;
        still_zero = 1'b1;
        for (int i = NUM_DIG - 1; i >= 1; i--) begin
            still_zero = still_zero && (bcd[i*4 +: 4] == 4'd0);
            blank[i]   = still_zero;
        end
        return blank;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - iterative double-dabble converter, one bit per cycle
module bin2bcd_seq
    import seg_disp_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    logic [BIN_W-1:0] shreg;
    logic [3:0]       iter;
    logic [BCD_W-1:0] adj;

    // Add-3 correction on every nibble that would overflow past 9 after the shift
    always_comb begin
        adj = bcd;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    // High during the cycle whose closing edge performs the last iteration
    assign done = busy && (iter == 4'd15);

    // Load on start, then shift one binary bit into the BCD register per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            iter  <= '0;
            busy  <= 1'b0;
            bcd   <= '0;
        end else if (start) begin
            shreg <= bin;
            iter  <= '0;
            busy  <= 1'b1;
            bcd   <= '0;
        end else if (busy) begin
            bcd   <= {adj[BCD_W-2:0], shreg[BIN_W-1]};
            shreg <= {shreg[BIN_W-2:0], 1'b0};
            iter  <= iter + 4'd1;
            if (iter == 4'd15) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg_disp_ctrl.sv
// rtl/seg_disp_ctrl.sv - page scheduler, page timer and BCD publisher (SEG_LZB_EN: leading-zero blanking)
module seg_disp_ctrl
    import seg_disp_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int PAGE_MS  = 2000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [15:0] src0_val,
    input  logic        src0_vld,
    input  logic [15:0] src1_val,
    input  logic        src1_vld,
    input  logic        alarm_req,
    input  logic [3:0]  alarm_code,
    input  logic        key_next,
    input  logic        auto_en,
    output logic [19:0] disp_bcd,
    output logic [4:0]  disp_blank,
    output logic [1:0]  disp_page,
    output logic        disp_upd
);

    localparam int PRE_DIV = (CLK_FREQ / 1000 > 0) ? CLK_FREQ / 1000 : 1;
    localparam int PRE_W   = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
    localparam int MS_W    = (PAGE_MS > 1) ? $clog2(PAGE_MS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_DIV - 1);
    localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(PAGE_MS - 1);

    state_t           state;
    logic             sel_page;
    logic             alarm_q;
    logic [3:0]       code_q;
    logic             pend;
    logic [1:0]       page_q;
    logic [PRE_W-1:0] pre_cnt;
    logic [MS_W-1:0]  ms_cnt;

    logic [1:0]       eff_page;
    logic [15:0]      launch_val;
    logic             run;
    logic             alarm_fall;
    logic             expire;
    logic             toggle;
    logic             trig;
    logic             launch;
    logic             conv_busy;
    logic             conv_done;
    logic [BCD_W-1:0] conv_bcd;

    assign run        = auto_en && !alarm_req;
    assign alarm_fall = alarm_q && !alarm_req;
    assign expire     = run && (pre_cnt == PRE_LAST) && (ms_cnt == MS_LAST);
    assign toggle     = (key_next && !alarm_req) || expire;

    // Alarm overrides the user-selected page
    always_comb begin
        eff_page = {1'b0, sel_page};
        if (alarm_req) begin
            eff_page = PG_ALARM;
        end
    end

    // Value belonging to the page that is about to be converted
    always_comb begin
        launch_val = src0_val;
        case (eff_page)
            PG_SET:   launch_val = src1_val;
            PG_ALARM: launch_val = {12'd0, alarm_code};
            default:  launch_val = src0_val;
        endcase
    end

    // A page toggle or an alarm edge both change the effective page in this cycle
    assign trig = ((eff_page == PG_MEAS) && src0_vld)
               || ((eff_page == PG_SET) && src1_vld)
               || toggle
               || (alarm_req != alarm_q)
               || (alarm_req && (alarm_code != code_q));

    assign launch = (state == ST_IDLE) && pend && !conv_busy;

    // Page timer: 1 ms prescaler feeding a ms counter, held at zero whenever it must not run
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pre_cnt <= '0;
            ms_cnt  <= '0;
        end else if (!run || key_next || alarm_fall) begin
            pre_cnt <= '0;
            ms_cnt  <= '0;
        end else if (pre_cnt == PRE_LAST) begin
            pre_cnt <= '0;
            ms_cnt  <= (ms_cnt == MS_LAST) ? '0 : ms_cnt + MS_W'(1);
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    // User page selection and the history used for edge/change detection
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sel_page <= 1'b0;
            alarm_q  <= 1'b0;
            code_q   <= 4'd0;
        end else begin
            if (toggle) begin
                sel_page <= !sel_page;
            end
            alarm_q <= alarm_req;
            code_q  <= alarm_code;
        end
    end

    // Pending flag: a new trigger wins over the clear at launch so nothing is lost
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pend <= 1'b1;
        end else begin
            pend <= trig || (pend && !launch);
        end
    end

    // Conversion sequencer: launch, wait for the converter, publish
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state  <= ST_IDLE;
            page_q <= PG_MEAS;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        state  <= ST_CONV;
                        page_q <= eff_page;
                    end
                end
                ST_CONV: begin
                    if (conv_done) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output registers change only together with the update strobe
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            disp_bcd  <= '0;
            disp_page <= PG_MEAS;
            disp_upd  <= 1'b0;
        end else begin
            disp_upd <= (state == ST_DONE);
            if (state == ST_DONE) begin
                disp_bcd  <= conv_bcd;
                disp_page <= page_q;
            end
        end
    end

`ifdef SEG_LZB_EN
    // Blank the leading zero digits of the value being published
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            disp_blank <= 5'b11110;
        end else if (state == ST_DONE) begin
            disp_blank <= lead_zero_blank(conv_bcd);
        end
    end
`else
    assign disp_blank = 5'b00000;
`endif

    bin2bcd_seq u_bin2bcd (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .start (launch),
        .bin   (launch_val),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

endmodule
